// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch
// (instruction) port and the memory-stage (data) port of a pipelined MIPS.
// Data requests win, except when fetch has watched STARVE consecutive data
// grants while waiting; then the next grant goes to fetch.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   ireq/iadr -> irdata/ivalid fetch request, address, returned word, done pulse
//   dreq/dwe/dadr/dwdata       data request, store flag, address, store data
//   drdata/dvalid              load data, done pulse
//   mreq/mwe/madr/mwdata       memory request and registered command
//   mrdata/mack                memory read data and completion
//   stall                      pipeline stall (combinational)
//   busy                       an access is in flight
module mem_port_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STARVE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ireq,
  input  logic [WIDTH-1:0] iadr,
  output logic [WIDTH-1:0] irdata,
  output logic             ivalid,
  input  logic             dreq,
  input  logic             dwe,
  input  logic [WIDTH-1:0] dadr,
  input  logic [WIDTH-1:0] dwdata,
  output logic [WIDTH-1:0] drdata,
  output logic             dvalid,
  output logic             mreq,
  output logic             mwe,
  output logic [WIDTH-1:0] madr,
  output logic [WIDTH-1:0] mwdata,
  input  logic [WIDTH-1:0] mrdata,
  input  logic             mack,
  output logic             stall,
  output logic             busy
);

  localparam int unsigned SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          fetch_force;

  // Fetch has been passed over STARVE times in a row and is still waiting.
  assign fetch_force = ireq & (streak == SW'(STARVE));

  // Arbitration, command capture and streak tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mwe    <= 1'b0;
      madr   <= '0;
      mwdata <= '0;
      streak <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq && !fetch_force) begin
            state  <= DBUSY;
            mwe    <= dwe;
            madr   <= dadr;
            mwdata <= dwdata;
            if (ireq) begin
              if (streak != SW'(STARVE)) streak <= streak + SW'(1);
            end else begin
              streak <= '0;
            end
          end else if (ireq) begin
            state  <= IBUSY;
            mwe    <= 1'b0;
            madr   <= iadr;
            mwdata <= '0;
            streak <= '0;
          end
        end
        IBUSY, DBUSY: begin
          if (mack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mreq   = (state != IDLE);
  assign busy   = (state != IDLE);

  // Completion pulses only while a grant is outstanding; mack in IDLE is ignored.
  assign ivalid = (state == IBUSY) & mack;
  assign dvalid = (state == DBUSY) & mack;

  assign irdata = mrdata;
  assign drdata = mrdata;

  assign stall  = (ireq & ~ivalid) | (dreq & ~dvalid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a randomized
// phase checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;

  localparam int unsigned W      = 32;
  localparam int unsigned STARVE = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ireq = 1'b0;
  logic [W-1:0] iadr = '0;
  logic [W-1:0] irdata;
  logic         ivalid;
  logic         dreq = 1'b0;
  logic         dwe = 1'b0;
  logic [W-1:0] dadr = '0;
  logic [W-1:0] dwdata = '0;
  logic [W-1:0] drdata;
  logic         dvalid;
  logic         mreq;
  logic         mwe;
  logic [W-1:0] madr;
  logic [W-1:0] mwdata;
  logic [W-1:0] mrdata;
  logic         mack;
  logic         stall;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.WIDTH(W), .STARVE(STARVE)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iadr(iadr), .irdata(irdata), .ivalid(ivalid),
    .dreq(dreq), .dwe(dwe), .dadr(dadr), .dwdata(dwdata),
    .drdata(drdata), .dvalid(dvalid),
    .mreq(mreq), .mwe(mwe), .madr(madr), .mwdata(mwdata),
    .mrdata(mrdata), .mack(mack), .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: acks after a configurable number of wait cycles.
  logic         rand_mode = 1'b0;
  logic         man_mode  = 1'b0;
  logic         man_mack  = 1'b0;
  logic         ovr_en    = 1'b0;
  logic [W-1:0] ovr_data  = '0;
  int           lat_fixed = 0;
  int           lat_rand  = 0;
  int           wcnt      = 0;
  logic         spur      = 1'b0;
  int           lat_eff;
  logic         auto_mack;

  function automatic logic [W-1:0] hash(input logic [W-1:0] a);
    return (a ^ 32'hA5C3_0000) + 32'h0000_1357;
  endfunction

  assign lat_eff   = rand_mode ? lat_rand : lat_fixed;
  assign auto_mack = mreq && (wcnt == lat_eff);
  assign mack      = man_mode ? man_mack : (mreq ? auto_mack : spur);
  assign mrdata    = ovr_en ? ovr_data : hash(madr);

  always @(posedge clk) begin
    if (!mreq || mack) wcnt <= 0;
    else               wcnt <= wcnt + 1;
    if (mreq && mack) lat_rand <= int'($urandom_range(0, 3));
    spur <= rand_mode && ($urandom_range(0, 3) == 0);
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Reference model state (transaction level).
  bit           m_busy = 0;
  bit           m_isd  = 0;
  bit           m_we   = 0;
  logic [W-1:0] m_adr  = '0;
  logic [W-1:0] m_wd   = '0;
  int unsigned  m_dwins = 0;   // data grants in a row that fetch sat through
  bit           e_iv, e_dv, iv_prev, dv_prev;
  bit           exp_d;

  initial begin
    // Reset and idle
    cyc(); settle();
    chk("rst_mreq", mreq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    cyc(); settle();
    chk("rst_ivalid", ivalid, 0);
    chk("rst_dvalid", dvalid, 0);
    reset = 1'b1;
    cyc(); settle();
    chk("idle_mreq", mreq, 0);
    chk("idle_busy", busy, 0);
    chk("idle_stall", stall, 0);

    // Single fetch, zero-wait memory
    cyc();
    lat_fixed = 0; ovr_en = 1'b1; ovr_data = 32'h2002_0005;
    ireq = 1'b1; iadr = 32'h0000_0004;
    settle();
    chk("f_n_mreq", mreq, 0);
    chk("f_n_stall", stall, 1);
    cyc(); settle();
    chk("f_n1_mreq", mreq, 1);
    chk("f_n1_madr", madr, 32'h4);
    chk("f_n1_ivalid", ivalid, 1);
    chk("f_n1_irdata", irdata, 32'h2002_0005);
    chk("f_n1_stall", stall, 0);
    ireq = 1'b0; ovr_en = 1'b0;
    cyc(); settle();
    chk("f_n2_busy", busy, 0);
    chk("f_n2_ivalid", ivalid, 0);

    // Store, three-cycle memory
    cyc();
    lat_fixed = 2;
    dreq = 1'b1; dwe = 1'b1; dadr = 32'd84; dwdata = 32'd4860;
    settle();
    chk("st_stall0", stall, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(); settle();
      chk("st_mreq", mreq, 1);
      chk("st_mwe", mwe, 1);
      chk("st_madr", madr, 32'd84);
      chk("st_mwdata", mwdata, 32'd4860);
      chk("st_dvalid", dvalid, (k == 2) ? 1 : 0);
      chk("st_stall", stall, (k == 2) ? 0 : 1);
    end
    dreq = 1'b0; dwe = 1'b0;
    cyc(); settle();
    chk("st_done_mreq", mreq, 0);

    // Conflict with starvation guard: D,D,D,D,I repeating
    cyc();
    lat_fixed = 0;
    ireq = 1'b1; iadr = 32'h8; dreq = 1'b1; dadr = 32'h10;
    settle();
    for (int g = 0; g < 10; g++) begin
      chk("sv_idle_busy", busy, 0);
      chk("sv_idle_stall", stall, 1);
      cyc(); settle();
      exp_d = ((g % 5) != 4);
      chk("sv_dvalid", dvalid, exp_d);
      chk("sv_ivalid", ivalid, !exp_d);
      cyc(); settle();
    end
    ireq = 1'b0; dreq = 1'b0;

    // Simultaneous single requests: data first, fetch two cycles later
    cyc();
    ovr_en = 1'b1; ovr_data = 32'd7;
    ireq = 1'b1; iadr = 32'h20; dreq = 1'b1; dwe = 1'b0; dadr = 32'd80;
    settle();
    chk("sim_n_mreq", mreq, 0);
    cyc(); settle();
    chk("sim_dvalid", dvalid, 1);
    chk("sim_drdata", drdata, 32'd7);
    chk("sim_madr", madr, 32'd80);
    chk("sim_ivalid0", ivalid, 0);
    dreq = 1'b0; ovr_en = 1'b0;
    cyc(); settle();
    chk("sim_gap_busy", busy, 0);
    chk("sim_gap_stall", stall, 1);
    cyc(); settle();
    chk("sim_ivalid", ivalid, 1);
    chk("sim_irdata", irdata, hash(32'h20));
    ireq = 1'b0;
    cyc(); settle();
    chk("sim_end_busy", busy, 0);

    // Reset mid-access
    cyc();
    lat_fixed = 5;
    dreq = 1'b1; dwe = 1'b0; dadr = 32'd40;
    settle();
    chk("rm_n_mreq", mreq, 0);
    cyc(); settle();
    chk("rm_mreq", mreq, 1);
    chk("rm_madr", madr, 32'd40);
    cyc(); settle();
    chk("rm_dvalid0", dvalid, 0);
    reset = 1'b0;
    settle();
    chk("rm_async_mreq", mreq, 0);
    chk("rm_async_busy", busy, 0);
    chk("rm_async_madr", madr, 0);
    chk("rm_async_stall", stall, 1);
    man_mode = 1'b1; man_mack = 1'b1;
    settle();
    chk("rm_late_dvalid", dvalid, 0);
    cyc(); settle();
    chk("rm_late_dvalid2", dvalid, 0);
    chk("rm_late_mreq", mreq, 0);
    man_mode = 1'b0; man_mack = 1'b0; lat_fixed = 0;
    reset = 1'b1;
    settle();
    chk("rm_rel_mreq", mreq, 0);
    cyc(); settle();
    chk("rm_regrant_mreq", mreq, 1);
    chk("rm_regrant_madr", madr, 32'd40);
    chk("rm_regrant_dvalid", dvalid, 1);
    chk("rm_regrant_drdata", drdata, hash(32'd40));
    dreq = 1'b0;
    cyc(); settle();
    chk("rm_end_busy", busy, 0);

    // Randomized traffic against the arbitration model
    rand_mode = 1'b1;
    iv_prev = 0; dv_prev = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (iv_prev) ireq = 1'b0;
      if (dv_prev) dreq = 1'b0;
      if (!ireq && $urandom_range(0, 1) == 1) begin
        ireq = 1'b1; iadr = $urandom;
      end
      if (!dreq && $urandom_range(0, 1) == 1) begin
        dreq = 1'b1; dwe = 1'($urandom_range(0, 1)); dadr = $urandom; dwdata = $urandom;
      end
      #1;
      e_iv = m_busy && !m_isd && mack;
      e_dv = m_busy && m_isd && mack;
      chk("rnd_mreq", mreq, m_busy);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_ivalid", ivalid, e_iv);
      chk("rnd_dvalid", dvalid, e_dv);
      chk("rnd_stall", stall, (ireq && !e_iv) || (dreq && !e_dv));
      if (m_busy) begin
        chk("rnd_madr", madr, m_adr);
        chk("rnd_mwe", mwe, m_we);
        chk("rnd_mwdata", mwdata, m_wd);
      end
      if (e_iv) chk("rnd_irdata", irdata, hash(m_adr));
      if (e_dv && !m_we) chk("rnd_drdata", drdata, hash(m_adr));
      // Advance the model across the coming edge.
      if (m_busy) begin
        if (mack) m_busy = 0;
      end else if (dreq && !(ireq && m_dwins >= STARVE)) begin
        m_busy = 1; m_isd = 1; m_we = dwe; m_adr = dadr; m_wd = dwdata;
        m_dwins = ireq ? m_dwins + 1 : 0;
      end else if (ireq) begin
        m_busy = 1; m_isd = 0; m_we = 0; m_adr = iadr; m_wd = '0;
        m_dwins = 0;
      end
      iv_prev = e_iv;
      dv_prev = e_dv;
    end
    rand_mode = 1'b0;
    ireq = 1'b0; dreq = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-ported memory between the pipelined MIPS fetch stage (instruction port) and memory stage (data port).
- Serialises accesses through a req/ack memory handshake.
- Generates the pipeline stall while either stage is waiting.
- Data has priority, with a starvation guard so fetch always progresses. Sits between the pipeline and the memory model in the top level.

Parameters:
- WIDTH, 32, data and address width.
- STARVE, 4, max consecutive data grants while ireq is pending before fetch is forced (≥1).

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- ireq  in  1  fetch access request; held with iadr until ivalid
- iadr  in  WIDTH  fetch address
- irdata  out  WIDTH  instruction word; valid when ivalid
- ivalid  out  1  fetch access completes this cycle
- dreq  in  1  data access request; held with dwe/dadr/dwdata until dvalid
- dwe  in  1  1 = store, 0 = load
- dadr  in  WIDTH  data address
- dwdata  in  WIDTH  store data
- drdata  out  WIDTH  load data; valid when dvalid
- dvalid  out  1  data access completes this cycle
- mreq  out  1  memory request
- mwe  out  1  memory write enable
- madr  out  WIDTH  memory address
- mwdata  out  WIDTH  memory write data
- mrdata  in  WIDTH  memory read data; valid with mack
- mack  in  1  memory completes the access this cycle; sampled only while mreq = 1
- stall  out  1  pipeline stall, combinational
- busy  out  1  state != IDLE

Behaviour:

FSM states: IDLE, IBUSY, DBUSY. Transitions:
- IDLE, dreq & ~force → DBUSY; latch dwe/dadr/dwdata into mwe/madr/mwdata.
- IDLE, ireq & (~dreq | force) → IBUSY; latch iadr into madr, mwe = 0, mwdata = 0.
- IDLE, no request → stay IDLE.
- force = ireq & (streak == STARVE).
- IBUSY/DBUSY: stay until mack = 1, then → IDLE on that edge.

Outputs:
- mreq = 1 exactly in IBUSY/DBUSY (registered state). mwe/madr/mwdata are registered and stable for the whole busy period.
- ivalid = (state == IBUSY) & mack; dvalid = (state == DBUSY) & mack. Both are combinational, one-cycle pulses.
- irdata = drdata = mrdata, pass-through. Load data is sampled by the pipeline on the edge ending the valid cycle. On stores, dvalid still pulses and drdata is don't-care.
- stall = (ireq & ~ivalid) | (dreq & ~dvalid).

Streak counter:
- Increments (saturating at STARVE) on each DBUSY grant while ireq = 1.
- Clears on any IBUSY grant, and on a DBUSY grant taken with ireq = 0.

Latency and throughput:
- Request asserted in IDLE cycle N → mreq in N+1. With mack in N+1, valid in N+1 and IDLE in N+2.
- Minimum: 2 cycles per access; back-to-back accesses are 2 cycles apart.
- Requester advances on the edge ending its valid cycle. A request still high in the next IDLE cycle is a new access.

Boundary conditions:
- Simultaneous ireq and dreq in IDLE → data wins unless force.
- Requests arriving during busy wait, with stall = 1, until the next IDLE.
- mack in IDLE is ignored; nothing changes.
- Request dropped mid-access: the access still completes on memory; valid still pulses.
- reset = 0 at any time, including mid-access, immediately and asynchronously sets:
  - state = IDLE, so mreq = 0, busy = 0, ivalid = dvalid = 0
  - mwe = 0, madr = 0, mwdata = 0, streak = 0
  - the in-flight access is abandoned; a late mack is ignored
- stall stays combinational during reset and follows the formula.
- Widths fixed at WIDTH; no address translation, no alignment checking.

Test Plan:
- Reset and idle: reset = 0 two cycles, release, no requests → mreq = 0, busy = 0, stall = 0, ivalid = dvalid = 0.
- Single fetch, zero-wait memory: ireq = 1, iadr = 0x00000004, memory returns 0x20020005 with mack on the first mreq cycle → mreq/madr = 4 in cycle N+1, ivalid = 1 and irdata = 0x20020005 in N+1, stall = 0 only in N+1.
- Store with 3-cycle memory latency: dreq = 1, dwe = 1, dadr = 84, dwdata = 4860 → mwe = 1, madr = 84, mwdata = 4860 held 3 cycles; dvalid pulses once on mack; stall = 1 until then.
- Conflict and starvation with STARVE = 4: ireq and dreq both held permanently → grant order D,D,D,D,I,D,D,D,D,I…; every grant separated by one IDLE cycle.
- Simultaneous single requests: ireq and dreq rise together, memory 1-cycle → data serviced first (load dadr = 80 returns 7), fetch second; ivalid two cycles after dvalid.
- Reset mid-access: reset = 0 while DBUSY with mack pending → mreq drops immediately; a later mack produces no dvalid; after release, a held dreq is re-granted from IDLE.
